// File: rtl/pc_npc_sequencer_pkg.sv
// Shared constants for the PC/nPC sequencer: FSM state encoding, instruction size, BA cond code.
package pc_npc_sequencer_pkg;

  localparam logic [0:0]  ST_RUN     = 1'b0;
  localparam logic [0:0]  ST_TRAP    = 1'b1;
  localparam logic [31:0] INSN_BYTES = 32'd4;
  localparam logic [3:0]  COND_BA    = 4'b1000;

endpackage

// File: rtl/pc_npc_sequencer_branch_target_adder.sv
// Bicc target: pc + word-scaled displacement, 32-bit wraparound.
module branch_target_adder (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_disp_ext,
  output logic [31:0] o_target
);

  logic [1:0] w_unused_disp_hi;

  // The top two displacement bits fall off the word scaling.
  assign w_unused_disp_hi = i_disp_ext[31:30];
  assign o_target         = i_pc + {i_disp_ext[29:0], 2'b00};

endmodule

// File: rtl/pc_npc_sequencer.sv
// SPARC PC/nPC sequencer with delayed control transfer and annul handling.
// Optional misaligned-target trap enabled by defining PC_ALIGN_TRAP_EN.
//
//   state | meaning
//   RUN   | normal sequencing, PC/nPC update on advance
//   TRAP  | misaligned target seen; PC/nPC frozen until trap_ack
module pc_npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_advance,
  input  logic [31:0] i_disp_ext,
  input  logic        i_is_bicc,
  input  logic        i_cond_true,
  input  logic        i_is_ba,
  input  logic        i_annul_bit,
  input  logic        i_is_jmpl,
  input  logic [31:0] i_jmpl_target,
  input  logic        i_trap_ack,
  output logic [31:0] o_pc,
  output logic [31:0] o_npc,
  output logic        o_annul_slot,
  output logic        o_align_trap
);

  import pc_npc_sequencer_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_annul;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic [31:0] w_next_npc;
  logic        w_next_annul;
  logic        w_check;
  logic        w_misalign;

  branch_target_adder u_bta (
    .i_pc       (r_pc),
    .i_disp_ext (i_disp_ext),
    .o_target   (w_target)
  );

  // An annulled slot always retires as a plain sequential step.
  always_comb begin
    w_next_pc    = r_npc;
    w_next_npc   = r_npc + INSN_BYTES;
    w_next_annul = 1'b0;
    w_check      = 1'b0;
    if (r_annul) begin
      w_check = 1'b0;
    end else if (i_is_jmpl) begin
      w_next_npc = i_jmpl_target;
      w_check    = 1'b1;
    end else if (i_is_bicc && i_is_ba && i_annul_bit) begin
      w_next_pc  = w_target;
      w_next_npc = w_target + INSN_BYTES;
      w_check    = 1'b1;
    end else if (i_is_bicc && i_cond_true) begin
      w_next_npc = w_target;
      w_check    = 1'b1;
    end else if (i_is_bicc && i_annul_bit) begin
      w_next_annul = 1'b1;
    end
  end

  assign w_misalign = w_check && (w_next_npc[1:0] != 2'b00);

`ifdef PC_ALIGN_TRAP_EN
  logic [0:0] r_state;
  logic       r_align_trap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_npc        <= RESET_PC + INSN_BYTES;
      r_annul      <= 1'b0;
      r_align_trap <= 1'b0;
      r_state      <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_advance) begin
            if (w_misalign) begin
              r_align_trap <= 1'b1;
              r_state      <= ST_TRAP;
            end else begin
              r_pc    <= w_next_pc;
              r_npc   <= w_next_npc;
              r_annul <= w_next_annul;
            end
          end
        end
        ST_TRAP: begin
          if (i_trap_ack) begin
            r_pc         <= RESET_PC;
            r_npc        <= RESET_PC + INSN_BYTES;
            r_annul      <= 1'b0;
            r_align_trap <= 1'b0;
            r_state      <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_align_trap = r_align_trap;
`else
  logic w_unused_trap;

  assign w_unused_trap = i_trap_ack ^ w_misalign;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC + INSN_BYTES;
      r_annul <= 1'b0;
    end else if (i_advance) begin
      r_pc    <= w_next_pc;
      r_npc   <= w_next_npc;
      r_annul <= w_next_annul;
    end
  end

  assign o_align_trap = 1'b0;
`endif

  assign o_pc         = r_pc;
  assign o_npc        = r_npc;
  assign o_annul_slot = r_annul;

endmodule

// File: doc/pc_npc_sequencer.md
# pc_npc_sequencer

Holds the SPARC PC/nPC pair and computes the next pair every instruction. Sits directly downstream of the sign extender: consumes its 32-bit sign-extended disp22 for Bicc branch targets and the ALU-produced JMPL target. Implements delayed control transfer, the annul bit, and an optional misaligned-target trap. Drives the instruction-memory fetch address.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- advance  input  1  control unit retires current instruction; PC/nPC update this edge
- disp_ext  input  32  sign-extended disp22 from the sign extender
- is_bicc  input  1  current instruction is Bicc
- cond_true  input  1  Bicc condition evaluated true
- is_ba  input  1  Bicc is branch-always (cond 1000)
- annul_bit  input  1  instruction a-bit
- is_jmpl  input  1  current instruction is JMPL
- jmpl_target  input  32  rs1+simm13 from ALU
- trap_ack  input  1  trap handler accepted the fault (used with trap option only)
- pc  output  32  current PC (registered)
- npc  output  32  current nPC (registered)
- annul_slot  output  1  instruction at pc is annulled; control unit squashes it
- align_trap  output  1  misaligned-target trap pending (trap option only)

## Operation
- States: RUN, TRAP. Reset -> RUN.
- Branch target = pc + (disp_ext << 2), 32-bit wraparound, no overflow flag.
- In RUN, on advance=1, priority order:
  - is_jmpl: pc<=npc, npc<=jmpl_target, annul_slot<=0.
  - is_bicc & is_ba & annul_bit: pc<=target, npc<=target+4, annul_slot<=0 (delay slot skipped).
  - is_bicc & cond_true: pc<=npc, npc<=target, annul_slot<=0.
  - is_bicc & !cond_true & annul_bit: pc<=npc, npc<=npc+4, annul_slot<=1.
  - otherwise: pc<=npc, npc<=npc+4, annul_slot<=0.
- annul_slot=1 marks the slot at the new pc; the next advance clears it and performs a sequential step regardless of is_bicc/is_jmpl (annulled instruction has no effect).
- advance=0: all registers hold.
- is_bicc and is_jmpl both high: is_jmpl wins.

## Timing
- Reset values: pc=RESET_PC, npc=RESET_PC+4, annul_slot=0, align_trap=0, state RUN. Reset overrides advance in the same cycle, including mid-trap.
- Latency: new pc/npc visible one cycle after the advance edge; no combinational input-to-output path.
- Back-to-back advance every cycle supported.
- pc/npc wrap from 32'hFFFF_FFFC to 32'h0000_0000.

## Configuration
- PC_ALIGN_TRAP_EN defined: any computed new npc (JMPL or Bicc) with bits[1:0]!=0 blocks the update, sets align_trap=1, enters TRAP; pc/npc hold, advance ignored. trap_ack=1 in TRAP: pc<=RESET_PC, npc<=RESET_PC+4, align_trap<=0, annul_slot<=0, -> RUN.
- Undefined: no check; align_trap tied 0, trap_ack ignored, TRAP state absent; low two bits of targets pass through unchanged.

## Structure
- Shared package: state encoding (RUN, TRAP), INSN_BYTES=4, Bicc cond code constant for BA.
- One sub-module natural: branch_target_adder (pc + disp_ext<<2, combinational).
- Registers and FSM in top module.

## Test plan
- Reset with RESET_PC=0, 3 advances, no CTI -> pc 0,4,8,12; npc 4,8,12,16; annul_slot=0.
- pc=0x100, npc=0x104, Bicc taken, disp_ext=0xFFFF_FFFC -> pc=0x104, npc=0xF0; next advance -> pc=0xF0.
- pc=0x200, npc=0x204, Bicc untaken, a=1 -> pc=0x204, annul_slot=1; next advance with is_jmpl=1 ignored -> pc=0x208, npc=0x20C, annul_slot=0.
- pc=0x300, BA a=1, disp_ext=0x10 -> pc=0x340, npc=0x344, annul_slot=0.
- JMPL, jmpl_target=0x1002 with PC_ALIGN_TRAP_EN -> align_trap=1, pc/npc hold through 2 advances; trap_ack -> pc=RESET_PC, align_trap=0. Without macro -> npc=0x1002.
- rst_n low during TRAP with advance=1 -> next cycle pc=RESET_PC, npc=RESET_PC+4, align_trap=0.
